seven_segments_decoder: RTL and testbench

SEVEN_SEGMENTS_DECODER -- requirements
Module: seven_segments_decoder

---
 rtl/seven_segments_decoder.sv | 87 ++++++++
 tb/tb_seven_segments_decoder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seven_segments_decoder.sv
// Seven-segment decoder with lamp-test / blank override and registered outputs.
// Segment order on the output bus: bit 6 = a ... bit 0 = g.
// ACTIVE_LOW inverts the whole segment bus after the priority logic, so the
// lamp-test, blank and reset patterns are inverted too. invalid is never inverted.
module seven_segments_decoder #(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit HEX_MODE   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit,
  input  logic       lamp_test,
  input  logic       blank,
  output logic [6:0] segments,
  output logic       invalid
);

  localparam logic [6:0] SEG_ALL_ON = 7'b1111111;
  localparam logic [6:0] SEG_ALL_OFF = 7'b0000000;
  // Reset value is "all dark" at the pins, whichever drive polarity is in use.
  localparam logic [6:0] SEG_RESET = ACTIVE_LOW ? SEG_ALL_ON : SEG_ALL_OFF;

  logic [6:0] glyph;
  logic       glyph_bad;
  logic [6:0] seg_hi;
  logic [6:0] segments_d;
  logic       invalid_d;
  logic [6:0] segments_q;
  logic       invalid_q;

  // Digit-to-glyph lookup; anything without a glyph falls to dark/invalid.
  always_comb begin
    glyph     = SEG_ALL_OFF;
    glyph_bad = 1'b1;
    case (digit)
      4'd0:  begin glyph = 7'b1111110; glyph_bad = 1'b0; end
      4'd1:  begin glyph = 7'b0110000; glyph_bad = 1'b0; end
      4'd2:  begin glyph = 7'b1101101; glyph_bad = 1'b0; end
      4'd3:  begin glyph = 7'b1111001; glyph_bad = 1'b0; end
      4'd4:  begin glyph = 7'b0110011; glyph_bad = 1'b0; end
      4'd5:  begin glyph = 7'b1011011; glyph_bad = 1'b0; end
      4'd6:  begin glyph = 7'b1011111; glyph_bad = 1'b0; end
      4'd7:  begin glyph = 7'b1110000; glyph_bad = 1'b0; end
      4'd8:  begin glyph = 7'b1111111; glyph_bad = 1'b0; end
      4'd9:  begin glyph = 7'b1111011; glyph_bad = 1'b0; end
      4'd10: if (HEX_MODE) begin glyph = 7'b1110111; glyph_bad = 1'b0; end
      4'd11: if (HEX_MODE) begin glyph = 7'b0011111; glyph_bad = 1'b0; end
      4'd12: if (HEX_MODE) begin glyph = 7'b1001110; glyph_bad = 1'b0; end
      4'd13: if (HEX_MODE) begin glyph = 7'b0111101; glyph_bad = 1'b0; end
      4'd14: if (HEX_MODE) begin glyph = 7'b1001111; glyph_bad = 1'b0; end
      4'd15: if (HEX_MODE) begin glyph = 7'b1000111; glyph_bad = 1'b0; end
      default: begin
        glyph     = SEG_ALL_OFF;
        glyph_bad = 1'b1;
      end
    endcase
  end

  // Override priority (lamp_test > blank > decode), then apply drive polarity.
  always_comb begin
    seg_hi    = glyph;
    invalid_d = glyph_bad;
    if (lamp_test) begin
      seg_hi    = SEG_ALL_ON;
      invalid_d = 1'b0;
    end else if (blank) begin
      seg_hi    = SEG_ALL_OFF;
      invalid_d = 1'b0;
    end
    segments_d = ACTIVE_LOW ? ~seg_hi : seg_hi;
  end

  // Output registers; reset forces dark segments and clears invalid immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segments_q <= SEG_RESET;
      invalid_q  <= 1'b0;
    end else begin
      segments_q <= segments_d;
      invalid_q  <= invalid_d;
    end
  end

  assign segments = segments_q;
  assign invalid  = invalid_q;

endmodule

// File: tb/tb_seven_segments_decoder.sv
// Bench for seven_segments_decoder: three instances (default, HEX_MODE, ACTIVE_LOW)
// share one stimulus; expected responses are queued and checked by a monitor.
module tb_seven_segments_decoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] digit;
  logic       lamp_test;
  logic       blank;

  logic [6:0] seg_def, seg_hex, seg_al;
  logic       inv_def, inv_hex, inv_al;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] d;
    logic [6:0] sd;   // default instance segments
    logic       id;   // default instance invalid
    logic [6:0] sh;   // HEX_MODE instance segments
    logic       ih;   // HEX_MODE instance invalid
    logic [6:0] sa;   // ACTIVE_LOW instance segments
    logic       ia;   // ACTIVE_LOW instance invalid
  } vec_t;

  vec_t sb[$];

  // Hand-written decode tables (active-high).
  logic [6:0] tbl_dec [16];
  logic [6:0] tbl_hex [16];

  seven_segments_decoder u_def (
    .clk(clk), .rst_n(rst_n), .digit(digit), .lamp_test(lamp_test),
    .blank(blank), .segments(seg_def), .invalid(inv_def)
  );

  seven_segments_decoder #(.HEX_MODE(1'b1)) u_hex (
    .clk(clk), .rst_n(rst_n), .digit(digit), .lamp_test(lamp_test),
    .blank(blank), .segments(seg_hex), .invalid(inv_hex)
  );

  seven_segments_decoder #(.ACTIVE_LOW(1'b1)) u_al (
    .clk(clk), .rst_n(rst_n), .digit(digit), .lamp_test(lamp_test),
    .blank(blank), .segments(seg_al), .invalid(inv_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check7(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic apply(input logic [3:0] d, input logic lt, input logic bl,
                       input logic [6:0] sd, input logic id,
                       input logic [6:0] sh, input logic ih,
                       input logic [6:0] sa, input logic ia);
    vec_t v;
    @(negedge clk);
    digit     = d;
    lamp_test = lt;
    blank     = bl;
    v.d = d; v.sd = sd; v.id = id; v.sh = sh; v.ih = ih; v.sa = sa; v.ia = ia;
    sb.push_back(v);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: each edge that samples a queued vector is checked 1 time unit later.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      vec_t v;
      v = sb.pop_front();
      check7($sformatf("def_seg d=%0d", v.d), seg_def, v.sd);
      check1($sformatf("def_inv d=%0d", v.d), inv_def, v.id);
      check7($sformatf("hex_seg d=%0d", v.d), seg_hex, v.sh);
      check1($sformatf("hex_inv d=%0d", v.d), inv_hex, v.ih);
      check7($sformatf("al_seg d=%0d", v.d), seg_al, v.sa);
      check1($sformatf("al_inv d=%0d", v.d), inv_al, v.ia);
    end
  end

  initial begin
    tbl_dec[0]  = 7'b1111110; tbl_dec[1]  = 7'b0110000; tbl_dec[2]  = 7'b1101101;
    tbl_dec[3]  = 7'b1111001; tbl_dec[4]  = 7'b0110011; tbl_dec[5]  = 7'b1011011;
    tbl_dec[6]  = 7'b1011111; tbl_dec[7]  = 7'b1110000; tbl_dec[8]  = 7'b1111111;
    tbl_dec[9]  = 7'b1111011;
    for (int i = 10; i < 16; i++) tbl_dec[i] = 7'b0000000;
    for (int i = 0; i < 10; i++) tbl_hex[i] = tbl_dec[i];
    tbl_hex[10] = 7'b1110111; tbl_hex[11] = 7'b0011111; tbl_hex[12] = 7'b1001110;
    tbl_hex[13] = 7'b0111101; tbl_hex[14] = 7'b1001111; tbl_hex[15] = 7'b1000111;

    digit = 4'd3; lamp_test = 1'b0; blank = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check7("rst_def_seg", seg_def, 7'b0000000);
    check1("rst_def_inv", inv_def, 1'b0);
    check7("rst_hex_seg", seg_hex, 7'b0000000);
    check7("rst_al_seg",  seg_al,  7'b1111111);
    check1("rst_al_inv",  inv_al,  1'b0);
    @(posedge clk); #1;
    check7("rst_hold_def_seg", seg_def, 7'b0000000);
    @(negedge clk);
    rst_n = 1'b1;

    // Decimal sweep 0-9.
    for (int i = 0; i < 10; i++) begin
      logic [3:0] d;
      d = 4'(i);
      apply(d, 1'b0, 1'b0, tbl_dec[i], 1'b0, tbl_hex[i], 1'b0, ~tbl_dec[i], 1'b0);
    end
    // Codes 10-15: invalid in decimal mode, A-F in hex mode.
    for (int i = 10; i < 16; i++) begin
      logic [3:0] d;
      d = 4'(i);
      apply(d, 1'b0, 1'b0, 7'b0000000, 1'b1, tbl_hex[i], 1'b0, 7'b1111111, 1'b1);
    end
    // Priority: lamp_test > blank > decode.
    apply(4'd3, 1'b1, 1'b1, 7'b1111111, 1'b0, 7'b1111111, 1'b0, 7'b0000000, 1'b0);
    apply(4'd3, 1'b0, 1'b1, 7'b0000000, 1'b0, 7'b0000000, 1'b0, 7'b1111111, 1'b0);
    apply(4'd3, 1'b0, 1'b0, 7'b1111001, 1'b0, 7'b1111001, 1'b0, 7'b0000110, 1'b0);
    // Overrides clear invalid for an otherwise invalid code.
    apply(4'd10, 1'b1, 1'b0, 7'b1111111, 1'b0, 7'b1111111, 1'b0, 7'b0000000, 1'b0);
    apply(4'd12, 1'b0, 1'b1, 7'b0000000, 1'b0, 7'b0000000, 1'b0, 7'b1111111, 1'b0);
    apply(4'd1, 1'b0, 1'b0, 7'b0110000, 1'b0, 7'b0110000, 1'b0, 7'b1001111, 1'b0);
    apply(4'd8, 1'b0, 1'b0, 7'b1111111, 1'b0, 7'b1111111, 1'b0, 7'b0000000, 1'b0);
    drain();

    // Mid-operation reset between edges with digit 8 held.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check7("midrst_def_seg", seg_def, 7'b0000000);
    check1("midrst_def_inv", inv_def, 1'b0);
    check7("midrst_al_seg",  seg_al,  7'b1111111);
    @(posedge clk); #1;
    check7("midrst_hold_def_seg", seg_def, 7'b0000000);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check7("release_no_stale_def", seg_def, 7'b0000000);
    @(posedge clk);
    @(posedge clk); #1;
    check7("post_rst_def_seg", seg_def, 7'b1111111);
    check1("post_rst_def_inv", inv_def, 1'b0);
    check7("post_rst_al_seg",  seg_al,  7'b0000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
